request_encoder: RTL and testbench
==================================

REQUEST_ENCODER -- requirements
Module: request_encoder

Interface
REQ-001 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-002 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port req_vld  input  1  one-cycle request strobe from AUX controller.
REQ-004 SHALL have port aux_ctrl_i2c_native  input  1  0 = native transaction, 1 = I2C-over-AUX; sampled with req_vld.
REQ-005 SHALL have port req_cmd  input  4  command nibble; native 1000 = write, 1001 = read; I2C {0,MOT,cmd[1:0]}, cmd[1:0]=00 = write.
REQ-006 SHALL have port req_addr  input  20  native: 20-bit DPCD address; I2C: [6:0] = 7-bit slave address.
REQ-007 SHALL have port req_len  input  5  payload byte count, 0..16.
REQ-008 SHALL have port wr_data  input  8  write payload byte from show-ahead source, valid in any cycle wr_data_rd=1.
REQ-009 SHALL have port wr_data_rd  output  1  pops one payload byte; wr_data sampled in the same cycle.
REQ-010 SHALL have port bdi_aux_out  output  8  request byte to AUX bit encoder.
REQ-011 SHALL have port bdi_aux_out_vld  output  1  high for every byte of a frame, contiguous, one byte per cycle.
REQ-012 SHALL have port enc_i2c_native  output  1  copy of captured aux_ctrl_i2c_native, held while bdi_aux_out_vld=1, else 0.
REQ-013 SHALL have port enc_busy  output  1  high from cycle after accepted req_vld through the enc_done cycle.
REQ-014 SHALL have port enc_done  output  1  one-cycle pulse in the cycle after the final frame byte.

Function
REQ-015 SHALL implement FSM states IDLE, HDR0, HDR1, HDR2, LEN, DATA, DONE; every output registered.
REQ-016 SHALL accept req_vld only in IDLE; capture cmd, addr, len, mode; go to HDR0; req_vld in any other state ignored.
REQ-017 SHALL drive first byte (HDR0) in the cycle after the accepting edge; latency req_vld -> bdi_aux_out_vld = 1 cycle.
REQ-018 SHALL emit native header: HDR0 = {cmd,addr[19:16]}, HDR1 = addr[15:8], HDR2 = addr[7:0].
REQ-019 SHALL emit I2C header: HDR0 = {cmd,4'b0000}, HDR1 = 8'h00, HDR2 = {1'b0,addr[6:0]}.
REQ-020 SHALL emit LEN byte = eff_len-1 (8 bits, zero-extended), eff_len = min(req_len,16).
REQ-021 SHALL treat native req_len=0 as eff_len=1 (LEN byte 8'h00).
REQ-022 SHALL, for I2C with req_len=0 (address-only), skip LEN and DATA: HDR2 -> DONE, 3-byte frame.
REQ-023 SHALL, for reads (native 1001, or I2C cmd[1:0]!=00), go LEN -> DONE with no payload.
REQ-024 SHALL, for writes, stay in DATA for exactly eff_len cycles, wr_data_rd=1 each cycle, bdi_aux_out = wr_data registered (byte appears next cycle).
REQ-025 SHALL count payload with 5-bit counter cleared on acceptance; no wrap beyond 16.
REQ-026 SHALL, in DONE, drive bdi_aux_out_vld=0, bdi_aux_out=8'h00, enc_done=1, then return to IDLE; a new req_vld is accepted the cycle after DONE.
REQ-027 SHALL drive bdi_aux_out=8'h00 whenever bdi_aux_out_vld=0.
REQ-028 SHALL never assert wr_data_rd outside DATA, nor for read or address-only frames.

Reset
REQ-029 SHALL, with rst_n=0 at a rising edge, set state IDLE, counter 0, bdi_aux_out 8'h00, bdi_aux_out_vld 0, enc_i2c_native 0, wr_data_rd 0, enc_busy 0, enc_done 0.
REQ-030 SHALL, on reset mid-frame, abort immediately with no enc_done; next req_vld after rst_n=1 starts a fresh frame.

Verification
REQ-031 Native write, cmd 1000, addr 20'h00102, len 2, payload A5,5A -> 80,01,02,01,A5,5A on consecutive cycles, wr_data_rd high 2 cycles, enc_done next cycle.
REQ-032 Native read, cmd 1001, addr 20'hF0000, len 16 -> 9F,00,00,0F; wr_data_rd never high; enc_busy 5 cycles.
REQ-033 I2C address-only write, cmd 0100, addr 7'h50, len 0 -> 40,00,50 with enc_i2c_native=1; enc_done after third byte.
REQ-034 I2C read, cmd 0001, addr 7'h50, len 20 -> 10,00,50,0F (clamped to 16).
REQ-035 req_vld pulsed during DATA of a native write len 4 -> ignored; frame exactly 8 bytes; following req_vld after DONE accepted.
REQ-036 rst_n low during HDR2 of a native read -> next cycle all outputs at reset values, no enc_done; new request after reset emits correct HDR0 one cycle later.

Source files
------------

// File: rtl/request_encoder.sv
// AUX request frame encoder: serialises a captured request into header, length and
// payload bytes, one byte per cycle, for the AUX bit encoder.
module request_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_vld,
  input  logic        aux_ctrl_i2c_native,
  input  logic [3:0]  req_cmd,
  input  logic [19:0] req_addr,
  input  logic [4:0]  req_len,
  input  logic [7:0]  wr_data,
  output logic        wr_data_rd,
  output logic [7:0]  bdi_aux_out,
  output logic        bdi_aux_out_vld,
  output logic        enc_i2c_native,
  output logic        enc_busy,
  output logic        enc_done
);

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StHdr2,
    StLen,
    StData,
    StDone
  } state_e;

  localparam logic [4:0] MaxLen = 5'd16;

  state_e      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [19:0] addr_q, addr_d;
  logic [4:0]  eff_len_q, eff_len_d;
  logic        i2c_q, i2c_d;
  logic        addr_only_q, addr_only_d;
  logic        is_read_q, is_read_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  out_q, out_d;
  logic        vld_q, vld_d;
  logic        rd_q, rd_d;
  logic        i2c_out_q, i2c_out_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [4:0]  req_eff_len;
  logic        req_is_read;
  logic        req_addr_only;
  logic [4:0]  cnt_inc;
  logic [7:0]  len_byte;

  // Native zero-length requests still carry one byte; I2C zero-length is address-only.
  always_comb begin
    req_eff_len = req_len;
    if (req_len > MaxLen) begin
      req_eff_len = MaxLen;
    end else if ((req_len == 5'd0) && !aux_ctrl_i2c_native) begin
      req_eff_len = 5'd1;
    end
    req_is_read   = aux_ctrl_i2c_native ? (req_cmd[1:0] != 2'b00) : (req_cmd == 4'b1001);
    req_addr_only = aux_ctrl_i2c_native && (req_len == 5'd0);
  end

  assign cnt_inc  = cnt_q + 5'd1;
  assign len_byte = {3'b000, eff_len_q - 5'd1};

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    addr_d      = addr_q;
    eff_len_d   = eff_len_q;
    i2c_d       = i2c_q;
    addr_only_d = addr_only_q;
    is_read_d   = is_read_q;
    cnt_d       = cnt_q;
    out_d       = 8'h00;
    vld_d       = 1'b0;
    rd_d        = 1'b0;
    i2c_out_d   = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (req_vld) begin
          cmd_d       = req_cmd;
          addr_d      = req_addr;
          eff_len_d   = req_eff_len;
          i2c_d       = aux_ctrl_i2c_native;
          addr_only_d = req_addr_only;
          is_read_d   = req_is_read;
          cnt_d       = 5'd0;
          out_d       = aux_ctrl_i2c_native ? {req_cmd, 4'b0000} : {req_cmd, req_addr[19:16]};
          vld_d       = 1'b1;
          i2c_out_d   = aux_ctrl_i2c_native;
          busy_d      = 1'b1;
          state_d     = StHdr0;
        end
      end

      StHdr0: begin
        out_d     = i2c_q ? 8'h00 : addr_q[15:8];
        vld_d     = 1'b1;
        i2c_out_d = i2c_q;
        busy_d    = 1'b1;
        state_d   = StHdr1;
      end

      StHdr1: begin
        out_d     = i2c_q ? {1'b0, addr_q[6:0]} : addr_q[7:0];
        vld_d     = 1'b1;
        i2c_out_d = i2c_q;
        busy_d    = 1'b1;
        state_d   = StHdr2;
      end

      StHdr2: begin
        busy_d = 1'b1;
        if (addr_only_q) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          out_d     = len_byte;
          vld_d     = 1'b1;
          i2c_out_d = i2c_q;
          // Pop the first payload byte while LEN is on the bus so data follows contiguously.
          rd_d      = !is_read_q;
          state_d   = StLen;
        end
      end

      StLen: begin
        busy_d = 1'b1;
        if (is_read_q) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          out_d     = wr_data;
          vld_d     = 1'b1;
          i2c_out_d = i2c_q;
          cnt_d     = 5'd1;
          rd_d      = (eff_len_q > 5'd1);
          state_d   = StData;
        end
      end

      StData: begin
        busy_d = 1'b1;
        if (cnt_q >= eff_len_q) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          out_d     = wr_data;
          vld_d     = 1'b1;
          i2c_out_d = i2c_q;
          cnt_d     = cnt_inc;
          rd_d      = (cnt_inc < eff_len_q);
          state_d   = StData;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cmd_q       <= 4'h0;
      addr_q      <= 20'h00000;
      eff_len_q   <= 5'd0;
      i2c_q       <= 1'b0;
      addr_only_q <= 1'b0;
      is_read_q   <= 1'b0;
      cnt_q       <= 5'd0;
      out_q       <= 8'h00;
      vld_q       <= 1'b0;
      rd_q        <= 1'b0;
      i2c_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      addr_q      <= addr_d;
      eff_len_q   <= eff_len_d;
      i2c_q       <= i2c_d;
      addr_only_q <= addr_only_d;
      is_read_q   <= is_read_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      vld_q       <= vld_d;
      rd_q        <= rd_d;
      i2c_out_q   <= i2c_out_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign wr_data_rd      = rd_q;
  assign bdi_aux_out     = out_q;
  assign bdi_aux_out_vld = vld_q;
  assign enc_i2c_native  = i2c_out_q;
  assign enc_busy        = busy_q;
  assign enc_done        = done_q;

endmodule

// File: tb/tb_request_encoder.sv
// Self-checking bench for request_encoder: directed vector table, reset corner case and
// randomized frames checked against a frame-level reference model.
module tb_request_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_vld;
  logic        aux_ctrl_i2c_native;
  logic [3:0]  req_cmd;
  logic [19:0] req_addr;
  logic [4:0]  req_len;
  logic [7:0]  wr_data;
  logic        wr_data_rd;
  logic [7:0]  bdi_aux_out;
  logic        bdi_aux_out_vld;
  logic        enc_i2c_native;
  logic        enc_busy;
  logic        enc_done;

  request_encoder u_dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .req_vld             (req_vld),
    .aux_ctrl_i2c_native (aux_ctrl_i2c_native),
    .req_cmd             (req_cmd),
    .req_addr            (req_addr),
    .req_len             (req_len),
    .wr_data             (wr_data),
    .wr_data_rd          (wr_data_rd),
    .bdi_aux_out         (bdi_aux_out),
    .bdi_aux_out_vld     (bdi_aux_out_vld),
    .enc_i2c_native      (enc_i2c_native),
    .enc_busy            (enc_busy),
    .enc_done            (enc_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] pay [16];
  logic [7:0] exp_q [$];
  int         exp_pops;

  typedef struct {
    logic        mode;
    logic [3:0]  cmd;
    logic [19:0] addr;
    logic [4:0]  len;
    logic [7:0]  p0;
    logic [7:0]  p1;
    int          nbytes;
    logic [31:0] hdr;
    int          pops;
    int          inject;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference built directly from the protocol rules.
  task automatic model_frame(input logic mode, input logic [3:0] cmd, input logic [19:0] addr,
                             input logic [4:0] len);
    int eff;
    bit is_rd;
    eff = (len > 5'd16) ? 16 : int'(len);
    if (!mode && eff == 0) eff = 1;
    is_rd = mode ? (cmd[1:0] != 2'b00) : (cmd == 4'b1001);
    exp_q.delete();
    exp_pops = 0;
    if (mode) begin
      exp_q.push_back({cmd, 4'b0000});
      exp_q.push_back(8'h00);
      exp_q.push_back({1'b0, addr[6:0]});
    end else begin
      exp_q.push_back({cmd, addr[19:16]});
      exp_q.push_back(addr[15:8]);
      exp_q.push_back(addr[7:0]);
    end
    if (mode && len == 5'd0) return;
    exp_q.push_back(8'(eff - 1));
    if (!is_rd) begin
      for (int k = 0; k < eff; k++) exp_q.push_back(pay[k]);
      exp_pops = eff;
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after enc_done.
  task automatic run_frame(input string tag, input logic mode, input logic [3:0] cmd,
                           input logic [19:0] addr, input logic [4:0] len, input int inject_at);
    logic [7:0] got [$];
    int pops, busy_cnt, done_at, i2c_err, idle_err;
    got.delete();
    pops = 0; busy_cnt = 0; done_at = -1; i2c_err = 0; idle_err = 0;
    chk({tag, " idle before"}, {31'd0, enc_busy}, 32'd0);
    aux_ctrl_i2c_native = mode;
    req_cmd = cmd;
    req_addr = addr;
    req_len = len;
    req_vld = 1'b1;
    wr_data = 8'($urandom);
    @(negedge clk);
    req_vld = 1'b0;
    for (int cyc = 0; cyc < 40 && done_at < 0; cyc++) begin
      if (cyc == inject_at) begin
        req_vld = 1'b1;
        aux_ctrl_i2c_native = 1'($urandom);
        req_cmd = 4'($urandom);
        req_addr = 20'($urandom);
        req_len = 5'($urandom);
      end else begin
        req_vld = 1'b0;
      end
      if (bdi_aux_out_vld) begin
        got.push_back(bdi_aux_out);
        if (enc_i2c_native !== mode) i2c_err++;
      end else if (bdi_aux_out !== 8'h00 || enc_i2c_native !== 1'b0) begin
        idle_err++;
      end
      if (enc_busy) busy_cnt++;
      if (wr_data_rd) begin
        wr_data = (pops < 16) ? pay[pops] : 8'hEE;
        pops++;
      end else begin
        wr_data = 8'($urandom);
      end
      if (enc_done) done_at = cyc;
      else @(negedge clk);
    end
    req_vld = 1'b0;
    chk({tag, " done seen"}, {31'd0, done_at >= 0}, 32'd1);
    chk({tag, " frame length"}, got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      chk($sformatf("%s byte %0d", tag, k), (k < got.size()) ? {24'd0, got[k]} : 32'hDEAD,
          {24'd0, exp_q[k]});
    chk({tag, " done cycle"}, done_at, exp_q.size());
    chk({tag, " busy cycles"}, busy_cnt, exp_q.size() + 1);
    chk({tag, " pops"}, pops, exp_pops);
    chk({tag, " i2c flag errs"}, i2c_err, 0);
    chk({tag, " idle bus errs"}, idle_err, 0);
    @(negedge clk);
    chk({tag, " idle after"}, {28'd0, enc_busy, enc_done, bdi_aux_out_vld, wr_data_rd}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] h;
    rst_n = 1'b0;
    req_vld = 1'b0;
    aux_ctrl_i2c_native = 1'b0;
    req_cmd = 4'h0;
    req_addr = 20'h0;
    req_len = 5'd0;
    wr_data = 8'h00;

    vecs[0] = '{1'b0, 4'h8, 20'h00102, 5'd2,  8'hA5, 8'h5A, 6,  32'h80010201, 2,  -1};
    vecs[1] = '{1'b0, 4'h9, 20'hF0000, 5'd16, 8'h00, 8'h00, 4,  32'h9F00000F, 0,  -1};
    vecs[2] = '{1'b1, 4'h4, 20'h00050, 5'd0,  8'h00, 8'h00, 3,  32'h40005000, 0,  -1};
    vecs[3] = '{1'b1, 4'h1, 20'h00050, 5'd20, 8'h00, 8'h00, 4,  32'h1000500F, 0,  -1};
    vecs[4] = '{1'b0, 4'h8, 20'hABCDE, 5'd4,  8'h11, 8'h22, 8,  32'h8ABCDE03, 4,  5};
    vecs[5] = '{1'b0, 4'h8, 20'h00000, 5'd0,  8'hC3, 8'h3C, 5,  32'h80000000, 1,  -1};
    vecs[6] = '{1'b1, 4'h0, 20'hFFFFF, 5'd16, 8'h96, 8'h69, 20, 32'h00007F0F, 16, -1};
    vecs[7] = '{1'b1, 4'h5, 20'h00032, 5'd0,  8'h00, 8'h00, 3,  32'h50003200, 0,  -1};

    repeat (2) @(negedge clk);
    chk("reset outputs", {22'd0, bdi_aux_out, bdi_aux_out_vld, enc_i2c_native, wr_data_rd,
                          enc_busy, enc_done}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 16; k++) pay[k] = (k == 0) ? vecs[i].p0 : (k == 1) ? vecs[i].p1 : 8'(k * 17);
      h = vecs[i].hdr;
      exp_q.delete();
      for (int k = 0; k < vecs[i].nbytes; k++) exp_q.push_back((k < 4) ? h[31 - 8*k -: 8] : pay[k - 4]);
      exp_pops = vecs[i].pops;
      run_frame($sformatf("vec%0d", i), vecs[i].mode, vecs[i].cmd, vecs[i].addr, vecs[i].len,
                vecs[i].inject);
    end

    // Reset asserted while HDR2 of a native read is on the bus.
    aux_ctrl_i2c_native = 1'b0;
    req_cmd = 4'h9;
    req_addr = 20'h12345;
    req_len = 5'd3;
    req_vld = 1'b1;
    @(negedge clk);
    req_vld = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst hdr2 byte", {24'd0, bdi_aux_out}, 32'h45);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst mid-frame outputs", {22'd0, bdi_aux_out, bdi_aux_out_vld, enc_i2c_native,
                                  wr_data_rd, enc_busy, enc_done}, 32'd0);
    rst_n = 1'b1;
    begin
      int stray;
      stray = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (enc_done || bdi_aux_out_vld || enc_busy) stray++;
      end
      chk("rst no resume", stray, 0);
    end
    for (int k = 0; k < 16; k++) pay[k] = 8'($urandom);
    model_frame(1'b0, 4'h8, 20'h4A5C3, 5'd3);
    run_frame("post-rst", 1'b0, 4'h8, 20'h4A5C3, 5'd3, -1);

    for (int i = 0; i < 40; i++) begin
      logic        m;
      logic [3:0]  c;
      logic [19:0] a;
      logic [4:0]  l;
      m = 1'($urandom);
      if (m) c = {1'b0, 3'($urandom)};
      else   c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : {3'b100, 1'($urandom)};
      a = 20'($urandom);
      l = 5'($urandom_range(0, 20));
      for (int k = 0; k < 16; k++) pay[k] = 8'($urandom);
      model_frame(m, c, a, l);
      run_frame($sformatf("rnd%0d", i), m, c, a, l,
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
